// File: rtl/sps_sched_pkg.sv
// rtl/sps_sched_pkg.sv - shared types and constants for the SPS layer scheduler
package sps_sched_pkg;

  localparam int FIELD_W  = 16;
  localparam int IDX_W    = 5;
  localparam int PERF_W   = 32;
  // One decoded code word: pool bit plus five 16-bit fields.
  localparam int LEN_CODE = 1 + 5 * FIELD_W;
  localparam logic MAXPOOL_CODE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LAUNCH,
    RUN,
    NEXT,
    NEXT2,
    DONE
  } state_e;

endpackage

// File: rtl/sps_layer_scheduler.sv
// rtl/sps_layer_scheduler.sv - walks the layer list, launching conv/pool engines per layer
// Optional run-cycle counter built only when SPS_SCHED_PERF_EN is defined.
module sps_layer_scheduler
  import sps_sched_pkg::*;
(
  input  logic               s_clk,
  input  logic               s_rst,
  input  logic               start,
  output logic               code_ready,
  input  logic               code_valid,
  input  logic               fetch_done,
  input  logic               code_is_pool,
  input  logic [FIELD_W-1:0] code_lif_thrd,
  input  logic [FIELD_W-1:0] code_bias_scale,
  input  logic [FIELD_W-1:0] code_in_ch,
  input  logic [FIELD_W-1:0] code_out_ch,
  input  logic [FIELD_W-1:0] code_img_size,
  output logic               conv_start,
  output logic               pool_start,
  input  logic               conv_done,
  input  logic               pool_done,
  output logic [FIELD_W-1:0] cfg_lif_thrd,
  output logic [FIELD_W-1:0] cfg_bias_scale,
  output logic [FIELD_W-1:0] cfg_in_ch,
  output logic [FIELD_W-1:0] cfg_out_ch,
  output logic [FIELD_W-1:0] cfg_img_size,
  output logic [IDX_W-1:0]   layer_idx,
  output logic               busy,
  output logic               sps_part_done,
  output logic               err_zero_layer,
  output logic [PERF_W-1:0]  perf_cycles
);

  state_e             state_q, state_d;
  logic               code_ready_q, code_ready_d;
  logic               pool_q, pool_d;
  logic [FIELD_W-1:0] lif_q, lif_d, bias_q, bias_d, in_ch_q, in_ch_d;
  logic [FIELD_W-1:0] out_ch_q, out_ch_d, img_q, img_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_q, err_d;
  logic               pend_q, pend_d;
  logic               zero_layer;
  logic               eng_done;

  assign zero_layer = (out_ch_q == '0) || (img_q == '0);
  // Only the engine that was launched may end the RUN phase.
  assign eng_done   = (pool_q == MAXPOOL_CODE) ? pool_done : conv_done;

  always_comb begin
    state_d      = state_q;
    code_ready_d = code_ready_q;
    pool_d       = pool_q;
    lif_d        = lif_q;
    bias_d       = bias_q;
    in_ch_d      = in_ch_q;
    out_ch_d     = out_ch_q;
    img_d        = img_q;
    idx_d        = idx_q;
    err_d        = err_q;
    pend_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = FETCH;
          code_ready_d = 1'b1;
          idx_d        = '0;
          err_d        = 1'b0;
        end
      end
      FETCH: begin
        if (code_valid && code_ready_q) begin
          pool_d       = code_is_pool;
          lif_d        = code_lif_thrd;
          bias_d       = code_bias_scale;
          in_ch_d      = code_in_ch;
          out_ch_d     = code_out_ch;
          img_d        = code_img_size;
          code_ready_d = 1'b0;
          state_d      = LAUNCH;
        end else if (fetch_done) begin
          code_ready_d = 1'b0;
          state_d      = DONE;
        end
      end
      LAUNCH: begin
        if (zero_layer) begin
          err_d   = 1'b1;
          state_d = NEXT;
        end else begin
          // A zero-latency engine may answer while its start is still high.
          pend_d  = eng_done;
          state_d = RUN;
        end
      end
      RUN: begin
        if (eng_done || pend_q) state_d = NEXT;
      end
      NEXT: begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = NEXT2;
      end
      NEXT2: begin
        if (fetch_done) begin
          state_d = DONE;
        end else begin
          state_d      = FETCH;
          code_ready_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q      <= IDLE;
      code_ready_q <= 1'b0;
      pool_q       <= 1'b0;
      lif_q        <= '0;
      bias_q       <= '0;
      in_ch_q      <= '0;
      out_ch_q     <= '0;
      img_q        <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_ready_q <= code_ready_d;
      pool_q       <= pool_d;
      lif_q        <= lif_d;
      bias_q       <= bias_d;
      in_ch_q      <= in_ch_d;
      out_ch_q     <= out_ch_d;
      img_q        <= img_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      pend_q       <= pend_d;
    end
  end

  assign code_ready     = code_ready_q;
  assign conv_start     = (state_q == LAUNCH) && !zero_layer && (pool_q != MAXPOOL_CODE);
  assign pool_start     = (state_q == LAUNCH) && !zero_layer && (pool_q == MAXPOOL_CODE);
  assign cfg_lif_thrd   = lif_q;
  assign cfg_bias_scale = bias_q;
  assign cfg_in_ch      = in_ch_q;
  assign cfg_out_ch     = out_ch_q;
  assign cfg_img_size   = img_q;
  assign layer_idx      = idx_q;
  assign busy           = (state_q != IDLE);
  assign sps_part_done  = (state_q == DONE);
  assign err_zero_layer = err_q;

`ifdef SPS_SCHED_PERF_EN
  logic [PERF_W-1:0] cnt_q, cnt_d, perf_q, perf_d, cnt_inc;

  always_comb begin
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + PERF_W'(1);
    cnt_d   = cnt_q;
    perf_d  = perf_q;
    if (state_q == LAUNCH && state_d == RUN) begin
      cnt_d = '0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_inc;
      if (state_d != RUN) perf_d = cnt_inc;
    end
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      cnt_q  <= '0;
      perf_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_sps_layer_scheduler.sv
// tb/tb_sps_layer_scheduler.sv - directed vector bench for sps_layer_scheduler
module tb_sps_layer_scheduler;

`ifdef SPS_SCHED_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        s_clk = 1'b0;
  logic        s_rst, start, code_ready, code_valid, fetch_done, code_is_pool;
  logic [15:0] code_lif_thrd, code_bias_scale, code_in_ch, code_out_ch, code_img_size;
  logic        conv_start, pool_start, conv_done, pool_done;
  logic [15:0] cfg_lif_thrd, cfg_bias_scale, cfg_in_ch, cfg_out_ch, cfg_img_size;
  logic [4:0]  layer_idx;
  logic        busy, sps_part_done, err_zero_layer;
  logic [31:0] perf_cycles;

  always #5 s_clk = ~s_clk;

  sps_layer_scheduler dut (
    .s_clk(s_clk), .s_rst(s_rst), .start(start),
    .code_ready(code_ready), .code_valid(code_valid), .fetch_done(fetch_done),
    .code_is_pool(code_is_pool), .code_lif_thrd(code_lif_thrd),
    .code_bias_scale(code_bias_scale), .code_in_ch(code_in_ch),
    .code_out_ch(code_out_ch), .code_img_size(code_img_size),
    .conv_start(conv_start), .pool_start(pool_start),
    .conv_done(conv_done), .pool_done(pool_done),
    .cfg_lif_thrd(cfg_lif_thrd), .cfg_bias_scale(cfg_bias_scale),
    .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch), .cfg_img_size(cfg_img_size),
    .layer_idx(layer_idx), .busy(busy), .sps_part_done(sps_part_done),
    .err_zero_layer(err_zero_layer), .perf_cycles(perf_cycles)
  );

  // Layer-list fetcher model
  logic        lay_pool [8];
  logic [15:0] lay_out [8];
  logic [15:0] lay_img [8];
  int          n_lay = 0;
  int          ptr = 0;
  logic [2:0]  cur;

  assign cur             = ptr[2:0];
  assign code_valid      = (ptr < n_lay);
  assign fetch_done      = (ptr >= n_lay);
  assign code_is_pool    = lay_pool[cur];
  assign code_out_ch     = lay_out[cur];
  assign code_img_size   = lay_img[cur];
  assign code_lif_thrd   = 16'hA000 + {13'd0, cur};
  assign code_bias_scale = 16'hB000 + {13'd0, cur};
  assign code_in_ch      = 16'h0010 + {13'd0, cur};

  always @(posedge s_clk) begin
    if (s_rst || sps_part_done) ptr <= 0;
    else if (code_valid && code_ready) ptr <= ptr + 1;
  end

  // Engine model: done pulses in the eng_lat-th RUN cycle after launch
  int   eng_lat = 10;
  logic auto_en = 1'b1;
  logic man_conv_done = 1'b0, man_pool_done = 1'b0;
  int   conv_cnt = 0, pool_cnt = 0;

  assign conv_done = (conv_cnt == 1) | man_conv_done;
  assign pool_done = (pool_cnt == 1) | man_pool_done;

  always @(posedge s_clk) begin
    if (s_rst) begin
      conv_cnt <= 0;
      pool_cnt <= 0;
    end else begin
      if (conv_start && auto_en) conv_cnt <= eng_lat;
      else if (conv_cnt > 0)     conv_cnt <= conv_cnt - 1;
      if (pool_start && auto_en) pool_cnt <= eng_lat;
      else if (pool_cnt > 0)     pool_cnt <= pool_cnt - 1;
    end
  end

  // Monitor: launch log, part-done count, handshake-to-launch latency
  int log_kind [256];
  int log_idx [256];
  int log_n = 0, pd_cnt = 0, cyc = 0, hs_cyc = 0, st_cyc = 0;

  always @(posedge s_clk) begin
    cyc <= cyc + 1;
    if (code_valid && code_ready) hs_cyc <= cyc;
    if ((conv_start || pool_start) && log_n < 256) begin
      log_kind[log_n] <= pool_start ? 1 : 0;
      log_idx[log_n]  <= int'(layer_idx);
      log_n           <= log_n + 1;
      st_cyc          <= cyc;
    end
    if (sps_part_done) pd_cnt <= pd_cnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int count_kind(input int base, input int kind);
    int c = 0;
    for (int i = base; i < log_n; i++) if (log_kind[i] == kind) c++;
    return c;
  endfunction

  task automatic set_layer(input int i, input logic p, input logic [15:0] oc, input logic [15:0] img);
    lay_pool[i] = p;
    lay_out[i]  = oc;
    lay_img[i]  = img;
  endtask

  task automatic pulse_start;
    @(negedge s_clk);
    start = 1'b1;
    @(posedge s_clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(negedge s_clk);
    while (busy && n < budget) begin
      @(negedge s_clk);
      n++;
    end
    check({name, "_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic run_pass(input string name, input int budget);
    pulse_start();
    wait_idle(name, budget);
  endtask

  task automatic wait_log(input string name, input int target, input int budget);
    int n = 0;
    while (log_n < target && n < budget) begin
      @(negedge s_clk);
      n++;
    end
    check({name, "_launch_seen"}, 64'(log_n >= target), 64'(1));
  endtask

  typedef struct {
    logic        is_pool;
    logic [15:0] out_ch;
    logic [15:0] img;
    int          lat;
    int          n_conv;
    int          n_pool;
    logic        err;
    logic [31:0] perf;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int b, p, n;
    vecs[0] = '{1'b0, 16'd4,  16'd8, 3,  1, 0, 1'b0, 32'd3};
    vecs[1] = '{1'b1, 16'd4,  16'd8, 5,  0, 1, 1'b0, 32'd5};
    vecs[2] = '{1'b0, 16'd0,  16'd8, 5,  0, 0, 1'b1, 32'd5};
    vecs[3] = '{1'b1, 16'd4,  16'd0, 5,  0, 0, 1'b1, 32'd5};
    vecs[4] = '{1'b0, 16'd16, 16'd1, 1,  1, 0, 1'b0, 32'd1};
    vecs[5] = '{1'b1, 16'd1,  16'd1, 25, 0, 1, 1'b0, 32'd25};
    for (int i = 0; i < 8; i++) set_layer(i, 1'b0, 16'd1, 16'd1);

    s_rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge s_clk);
    #1;
    check("rst_flags", 64'({busy, code_ready, conv_start, pool_start, sps_part_done,
                            err_zero_layer, layer_idx}), 64'(0));
    check("rst_cfg", 64'(cfg_lif_thrd | cfg_bias_scale | cfg_in_ch | cfg_out_ch | cfg_img_size), 64'(0));
    check("rst_perf", 64'(perf_cycles), 64'(0));
    @(negedge s_clk);
    s_rst = 1'b0;

    // Single-layer vectors
    for (int i = 0; i < 6; i++) begin
      set_layer(0, vecs[i].is_pool, vecs[i].out_ch, vecs[i].img);
      n_lay   = 1;
      eng_lat = vecs[i].lat;
      b = log_n;
      p = pd_cnt;
      run_pass($sformatf("v%0d", i), 200);
      check($sformatf("v%0d_conv_starts", i), 64'(count_kind(b, 0)), 64'(vecs[i].n_conv));
      check($sformatf("v%0d_pool_starts", i), 64'(count_kind(b, 1)), 64'(vecs[i].n_pool));
      check($sformatf("v%0d_err", i), 64'(err_zero_layer), 64'(vecs[i].err));
      check($sformatf("v%0d_layer_idx", i), 64'(layer_idx), 64'(1));
      check($sformatf("v%0d_perf", i), 64'(perf_cycles), PERF_EN ? 64'(vecs[i].perf) : 64'(0));
      check($sformatf("v%0d_cfg", i), {32'd0, cfg_out_ch, cfg_img_size}, {32'd0, vecs[i].out_ch, vecs[i].img});
      check($sformatf("v%0d_part_done", i), 64'(pd_cnt - p), 64'(1));
    end

    // conv, pool, conv with 10-cycle engines
    set_layer(0, 1'b0, 16'd8, 16'd32);
    set_layer(1, 1'b1, 16'd8, 16'd16);
    set_layer(2, 1'b0, 16'd4, 16'd8);
    n_lay = 3;
    eng_lat = 10;
    b = log_n;
    p = pd_cnt;
    run_pass("three", 500);
    check("three_n_launch", 64'(log_n - b), 64'(3));
    for (int i = 0; i < 3; i++)
      check($sformatf("three_launch%0d", i), 64'(log_kind[b+i] * 256 + log_idx[b+i]),
            64'((i == 1 ? 256 : 0) + i));
    check("three_part_done", 64'(pd_cnt - p), 64'(1));
    check("three_layer_idx", 64'(layer_idx), 64'(3));
    check("three_cfg_held", 64'({cfg_lif_thrd, cfg_bias_scale, cfg_out_ch}), 64'({16'hA002, 16'hB002, 16'd4}));
    check("three_launch_latency", 64'(st_cyc - hs_cyc), 64'(1));
    check("three_err", 64'(err_zero_layer), 64'(0));

    // Degenerate first layer is skipped, next still runs
    set_layer(0, 1'b0, 16'd0, 16'd8);
    set_layer(1, 1'b1, 16'd2, 16'd4);
    n_lay = 2;
    b = log_n;
    p = pd_cnt;
    run_pass("zero", 300);
    check("zero_launches", 64'(log_n - b), 64'(1));
    check("zero_launch_kind_idx", 64'(log_kind[b] * 256 + log_idx[b]), 64'(256 + 1));
    check("zero_err", 64'(err_zero_layer), 64'(1));
    check("zero_layer_idx", 64'(layer_idx), 64'(2));

    // pool_done during a conv RUN must be ignored
    set_layer(0, 1'b0, 16'd3, 16'd3);
    n_lay = 1;
    eng_lat = 20;
    b = log_n;
    p = pd_cnt;
    pulse_start();
    wait_log("xdone", b + 1, 50);
    repeat (3) @(negedge s_clk);
    man_pool_done = 1'b1;
    @(negedge s_clk);
    man_pool_done = 1'b0;
    repeat (3) @(negedge s_clk);
    check("xdone_still_busy", 64'(busy), 64'(1));
    wait_idle("xdone", 100);
    check("xdone_perf", 64'(perf_cycles), PERF_EN ? 64'(20) : 64'(0));
    check("xdone_part_done", 64'(pd_cnt - p), 64'(1));

    // Second start while busy is ignored
    eng_lat = 10;
    b = log_n;
    p = pd_cnt;
    pulse_start();
    repeat (4) @(negedge s_clk);
    pulse_start();
    wait_idle("restart", 100);
    repeat (20) @(negedge s_clk);
    check("restart_busy", 64'(busy), 64'(0));
    check("restart_part_done", 64'(pd_cnt - p), 64'(1));
    check("restart_launches", 64'(log_n - b), 64'(1));

    // Done arriving in the LAUNCH cycle is kept
    auto_en = 1'b0;
    p = pd_cnt;
    pulse_start();
    n = 0;
    @(negedge s_clk);
    while (!conv_start && n < 20) begin
      @(negedge s_clk);
      n++;
    end
    check("zlat_conv_start", 64'(conv_start), 64'(1));
    man_conv_done = 1'b1;
    @(posedge s_clk);
    #1 man_conv_done = 1'b0;
    wait_idle("zlat", 10);
    check("zlat_part_done", 64'(pd_cnt - p), 64'(1));
    check("zlat_perf", 64'(perf_cycles), PERF_EN ? 64'(1) : 64'(0));
    auto_en = 1'b1;

    // Empty list: straight to DONE
    n_lay = 0;
    b = log_n;
    p = pd_cnt;
    run_pass("empty", 50);
    check("empty_part_done", 64'(pd_cnt - p), 64'(1));
    check("empty_launches", 64'(log_n - b), 64'(0));
    check("empty_layer_idx", 64'(layer_idx), 64'(0));

    // Reset in RUN of layer 1, then replay from layer 0
    set_layer(0, 1'b0, 16'd8, 16'd32);
    set_layer(1, 1'b1, 16'd8, 16'd16);
    set_layer(2, 1'b0, 16'd4, 16'd8);
    n_lay = 3;
    eng_lat = 10;
    b = log_n;
    p = pd_cnt;
    pulse_start();
    wait_log("rstrun", b + 2, 100);
    repeat (2) @(negedge s_clk);
    check("rstrun_pre", 64'({busy, layer_idx}), 64'({1'b1, 5'd1}));
    s_rst = 1'b1;
    @(posedge s_clk);
    #1;
    check("rstrun_flags", 64'({busy, code_ready, conv_start, pool_start, sps_part_done,
                               err_zero_layer, layer_idx}), 64'(0));
    check("rstrun_cfg", 64'(cfg_lif_thrd | cfg_bias_scale | cfg_in_ch | cfg_out_ch | cfg_img_size), 64'(0));
    check("rstrun_perf", 64'(perf_cycles), 64'(0));
    @(negedge s_clk);
    s_rst = 1'b0;
    repeat (30) @(negedge s_clk);
    check("rstrun_no_part_done", 64'(pd_cnt - p), 64'(0));
    check("rstrun_idle", 64'(busy), 64'(0));
    b = log_n;
    run_pass("replay", 500);
    check("replay_launches", 64'(log_n - b), 64'(3));
    check("replay_first", 64'(log_kind[b] * 256 + log_idx[b]), 64'(0));
    check("replay_layer_idx", 64'(layer_idx), 64'(3));
    check("replay_part_done", 64'(pd_cnt - p), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
